// File: rtl/snake_game_fsm.sv
// Game-state controller for the snake game. It sequences start, play, pause, death flash,
// restart and game-over, and tracks the remaining lives.
module snake_game_fsm #(
  parameter int RESTART_CYCLES = 6,
  parameter int FLASH_HALF     = 25_000_000,
  parameter int FLASH_TOGGLES  = 6,
  parameter int DIE_HOLD       = 200_000_000,
  parameter int LIVES          = 3,
  parameter int CNT_W          = 32
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       key1_press,
  input  logic       key2_press,
  input  logic       key3_press,
  input  logic       key4_press,
  input  logic       key_pause,
  input  logic       hit_wall,
  input  logic       hit_body,
  output logic [2:0] game_status,
  output logic       die_flash,
  output logic       restart,
  output logic       respawn,
  output logic [3:0] lives_left,
  output logic       game_over
);

  typedef enum logic [2:0] {
    ST_RESTART = 3'd0,
    ST_START   = 3'd1,
    ST_PLAY    = 3'd2,
    ST_DIE     = 3'd3,
    ST_PAUSE   = 3'd4,
    ST_OVER    = 3'd5
  } state_t;

  localparam logic [CNT_W-1:0] DIE_LAST     = CNT_W'(DIE_HOLD - 1);
  localparam logic [CNT_W-1:0] RESTART_LAST = CNT_W'(RESTART_CYCLES - 1);
  localparam logic [3:0]       LIVES_INIT   = 4'(LIVES);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             flash_nxt, restart_nxt, respawn_nxt, game_over_nxt;
  logic [3:0]       lives_nxt;
  logic             any_key;
  logic             flash_hit;

  assign any_key     = key1_press | key2_press | key3_press | key4_press;
  assign game_status = state;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= ST_START;
      cnt        <= '0;
      die_flash  <= 1'b1;
      restart    <= 1'b0;
      respawn    <= 1'b0;
      lives_left <= LIVES_INIT;
      game_over  <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      die_flash  <= flash_nxt;
      restart    <= restart_nxt;
      respawn    <= respawn_nxt;
      lives_left <= lives_nxt;
      game_over  <= game_over_nxt;
    end
  end

  // Flash toggles land on exact multiples of FLASH_HALF; a few constant compares avoid a divider.
  always_comb begin
    flash_hit = 1'b0;
    for (int k = 1; k <= FLASH_TOGGLES; k++) begin
      if (cnt == CNT_W'(k * FLASH_HALF)) flash_hit = 1'b1;
    end
  end

  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    flash_nxt     = die_flash;
    restart_nxt   = restart;
    respawn_nxt   = respawn;
    lives_nxt     = lives_left;
    game_over_nxt = game_over;

    case (state)
      ST_START: begin
        if (any_key) state_nxt = ST_PLAY;
      end
      ST_PLAY: begin
        if (hit_wall | hit_body) begin
          state_nxt = ST_DIE;
          cnt_nxt   = '0;
          lives_nxt = (lives_left == 4'd0) ? 4'd0 : lives_left - 4'd1;
        end else if (key_pause) begin
          state_nxt = ST_PAUSE;
        end
      end
      ST_PAUSE: begin
        if (key_pause) state_nxt = ST_PLAY;
      end
      ST_DIE: begin
        if (cnt == DIE_LAST) begin
          cnt_nxt   = '0;
          flash_nxt = 1'b1;
          if (lives_left != 4'd0) begin
            state_nxt   = ST_RESTART;
            restart_nxt = 1'b1;
            respawn_nxt = 1'b1;
          end else begin
            state_nxt     = ST_OVER;
            game_over_nxt = 1'b1;
          end
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
          if (flash_hit) flash_nxt = ~die_flash;
        end
      end
      ST_RESTART: begin
        if (cnt == RESTART_LAST) begin
          state_nxt   = ST_START;
          restart_nxt = 1'b0;
          respawn_nxt = 1'b0;
          cnt_nxt     = '0;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      ST_OVER: begin
        if (any_key | key_pause) begin
          state_nxt     = ST_RESTART;
          cnt_nxt       = '0;
          restart_nxt   = 1'b1;
          respawn_nxt   = 1'b0;
          lives_nxt     = LIVES_INIT;
          game_over_nxt = 1'b0;
        end
      end
      default: begin
        // Unused encodings recover to the reset picture.
        state_nxt     = ST_START;
        cnt_nxt       = '0;
        flash_nxt     = 1'b1;
        restart_nxt   = 1'b0;
        respawn_nxt   = 1'b0;
        lives_nxt     = LIVES_INIT;
        game_over_nxt = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_snake_game_fsm.sv
// Randomised self-checking bench for snake_game_fsm, compared each cycle against a
// behavioural model that counts time spent in each game phase.
module tb_snake_game_fsm;

  localparam int RC  = 3;
  localparam int FH  = 4;
  localparam int FT  = 6;
  localparam int DH  = 32;
  localparam int LV  = 2;

  localparam int M_RESTART = 0;
  localparam int M_START   = 1;
  localparam int M_PLAY    = 2;
  localparam int M_DIE     = 3;
  localparam int M_PAUSE   = 4;
  localparam int M_OVER    = 5;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       key1_press = 1'b0, key2_press = 1'b0, key3_press = 1'b0, key4_press = 1'b0;
  logic       key_pause = 1'b0, hit_wall = 1'b0, hit_body = 1'b0;
  logic [2:0] game_status;
  logic       die_flash, restart, respawn, game_over;
  logic [3:0] lives_left;

  int tests_run = 0;
  int tests_failed = 0;

  // Reference model: current phase, cycles spent in it, lives, and whether this restart respawns.
  int  m_status;
  int  m_time;
  int  m_lives;
  bit  m_respawn_mode;

  snake_game_fsm #(
    .RESTART_CYCLES(RC), .FLASH_HALF(FH), .FLASH_TOGGLES(FT),
    .DIE_HOLD(DH), .LIVES(LV), .CNT_W(32)
  ) dut (
    .clk(clk), .reset(reset),
    .key1_press(key1_press), .key2_press(key2_press),
    .key3_press(key3_press), .key4_press(key4_press),
    .key_pause(key_pause), .hit_wall(hit_wall), .hit_body(hit_body),
    .game_status(game_status), .die_flash(die_flash), .restart(restart),
    .respawn(respawn), .lives_left(lives_left), .game_over(game_over)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input int observed, input int expected);
    tests_run++;
    if (observed != expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", tag, observed, expected, $time);
    end
  endtask

  function automatic void modelReset();
    m_status       = M_START;
    m_time         = 0;
    m_lives        = LV;
    m_respawn_mode = 1'b0;
  endfunction

  function automatic void enterPhase(input int next_status);
    m_status = next_status;
    m_time   = 0;
  endfunction

  function automatic void modelStep(input bit any, input bit pause, input bit hit);
    case (m_status)
      M_START:   if (any) enterPhase(M_PLAY);
      M_PLAY: begin
        if (hit) begin
          m_lives = (m_lives > 0) ? m_lives - 1 : 0;
          enterPhase(M_DIE);
        end else if (pause) begin
          enterPhase(M_PAUSE);
        end
      end
      M_PAUSE:   if (pause) enterPhase(M_PLAY);
      M_DIE: begin
        if (m_time == DH - 1) begin
          if (m_lives > 0) begin
            m_respawn_mode = 1'b1;
            enterPhase(M_RESTART);
          end else begin
            enterPhase(M_OVER);
          end
        end else begin
          m_time++;
        end
      end
      M_RESTART: begin
        if (m_time == RC - 1) enterPhase(M_START);
        else m_time++;
      end
      M_OVER: begin
        if (any || pause) begin
          m_lives        = LV;
          m_respawn_mode = 1'b0;
          enterPhase(M_RESTART);
        end
      end
      default: modelReset();
    endcase
  endfunction

  // The flash pattern is the parity of how many toggle points lie strictly before this DIE cycle.
  function automatic int expFlash();
    int toggles;
    if (m_status != M_DIE || m_time == 0) return 1;
    toggles = (m_time - 1) / FH;
    if (toggles > FT) toggles = FT;
    return (toggles % 2 == 0) ? 1 : 0;
  endfunction

  task automatic checkAll(input string phase);
    checkOutput({phase, ".status"},    int'(game_status), m_status);
    checkOutput({phase, ".die_flash"}, int'(die_flash),   expFlash());
    checkOutput({phase, ".restart"},   int'(restart),     (m_status == M_RESTART) ? 1 : 0);
    checkOutput({phase, ".respawn"},   int'(respawn),     (m_status == M_RESTART && m_respawn_mode) ? 1 : 0);
    checkOutput({phase, ".lives"},     int'(lives_left),  m_lives);
    checkOutput({phase, ".game_over"}, int'(game_over),   (m_status == M_OVER) ? 1 : 0);
  endtask

  task automatic checkResetValues(input string phase);
    checkOutput({phase, ".status"},    int'(game_status), M_START);
    checkOutput({phase, ".die_flash"}, int'(die_flash),   1);
    checkOutput({phase, ".restart"},   int'(restart),     0);
    checkOutput({phase, ".respawn"},   int'(respawn),     0);
    checkOutput({phase, ".lives"},     int'(lives_left),  LV);
    checkOutput({phase, ".game_over"}, int'(game_over),   0);
  endtask

  // One clock of stimulus: drive after a falling edge, step the model on the rising edge,
  // and compare on the next falling edge.
  task automatic applyStimulus(input string phase, input logic [3:0] keys, input logic pause,
                               input logic wall, input logic body);
    key1_press = keys[0];
    key2_press = keys[1];
    key3_press = keys[2];
    key4_press = keys[3];
    key_pause  = pause;
    hit_wall   = wall;
    hit_body   = body;
    @(posedge clk);
    modelStep(|keys, pause, wall | body);
    @(negedge clk);
    checkAll(phase);
  endtask

  task automatic idle(input string phase, input int cycles);
    for (int i = 0; i < cycles; i++) applyStimulus(phase, 4'b0000, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    modelReset();
    repeat (2) @(negedge clk);
    checkResetValues("reset");
    reset = 1'b1;

    idle("idle0", 2);
    applyStimulus("start", 4'b0010, 1'b0, 1'b0, 1'b0);
    idle("play", 2);
    applyStimulus("die1", 4'b0000, 1'b0, 1'b1, 1'b0);
    idle("flash1", DH + RC + 2);

    applyStimulus("start2", 4'b0001, 1'b0, 1'b0, 1'b0);
    applyStimulus("pause", 4'b0000, 1'b1, 1'b0, 1'b0);
    applyStimulus("paused_hit", 4'b1000, 1'b0, 1'b0, 1'b1);
    idle("paused", 2);
    applyStimulus("resume", 4'b0000, 1'b1, 1'b0, 1'b0);

    applyStimulus("die2", 4'b0000, 1'b0, 1'b1, 1'b0);
    idle("flash2", DH + 2);
    applyStimulus("over_key", 4'b0001, 1'b0, 1'b0, 1'b0);
    idle("restart_game", RC + 1);

    applyStimulus("start3", 4'b0100, 1'b0, 1'b0, 1'b0);
    applyStimulus("triple", 4'b0000, 1'b1, 1'b1, 1'b1);
    idle("flash3", DH + RC + 2);

    for (int i = 0; i < 3000; i++) begin
      applyStimulus("rand",
                    4'(($urandom_range(0, 7) == 0) ? (1 << $urandom_range(0, 3)) : 0),
                    1'($urandom_range(0, 9) == 0),
                    1'($urandom_range(0, 11) == 0),
                    1'($urandom_range(0, 11) == 0));
    end

    if (m_status == M_OVER) applyStimulus("to_play", 4'b0000, 1'b1, 1'b0, 1'b0);
    idle("settle", RC + 2);
    applyStimulus("to_play2", 4'b0001, 1'b0, 1'b0, 1'b0);
    applyStimulus("die_rst", 4'b0000, 1'b0, 1'b0, 1'b1);
    idle("mid_die", 10);
    #2 reset = 1'b0;
    #1 checkResetValues("async_reset");
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkResetValues("held_reset");
    reset = 1'b1;
    modelReset();
    idle("post_reset", 2);
    applyStimulus("post_start", 4'b1000, 1'b0, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
